// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 VGA timing generator that fetches a grayscale
// image from VRAM (one pixel per clock) and places it at the top-left of the
// active area, scaled up by 2^SCALE_SHIFT. It drives pipeline-aligned
// hsync/vsync/video-enable and 12-bit RGB.
module vga_frame_reader #(
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned IMG_W        = 320,
  parameter int unsigned IMG_H        = 240,
  parameter int unsigned SCALE_SHIFT  = 1,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] pixel_data_i,
  output logic [ADDR_WIDTH-1:0] pixel_read_address_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  video_en_o,
  output logic [11:0]           rgb_o,
  output logic                  frame_start_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] V_MASK = V_W'((1 << SCALE_SHIFT) - 1);

  // Per-pixel control flags carried alongside the VRAM read.
  typedef struct packed {
    logic first;
    logic in_img;
    logic active;
    logic vs;
    logic hs;
  } flags_t;

  localparam flags_t FLAGS_RST = '{first: 1'b0, in_img: 1'b0, active: 1'b0,
                                   vs: 1'b1, hs: 1'b1};

  logic [H_W-1:0]        r_h_cnt;
  logic [V_W-1:0]        r_v_cnt;
  logic [ADDR_WIDTH-1:0] r_line_base;
  logic [ADDR_WIDTH-1:0] r_addr;
  flags_t                r_pipe [READ_LATENCY+1];
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_video_en;
  logic [11:0]           r_rgb;
  logic                  r_frame_start;

  logic                  w_h_wrap;
  logic                  w_v_wrap;
  logic [H_W-1:0]        w_h_img;
  logic [V_W-1:0]        w_v_img;
  logic                  w_active;
  logic                  w_in_img;
  logic                  w_row_end;
  logic [ADDR_WIDTH-1:0] w_col;
  flags_t                w_flags;
  logic [3:0]            w_nib;
  logic                  w_unused_pix;

  assign w_h_wrap  = (r_h_cnt == H_LAST);
  assign w_v_wrap  = (r_v_cnt == V_LAST);
  assign w_h_img   = r_h_cnt >> SCALE_SHIFT;
  assign w_v_img   = r_v_cnt >> SCALE_SHIFT;
  assign w_active  = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_in_img  = w_active && (32'(w_h_img) < IMG_W) && (32'(w_v_img) < IMG_H);
  assign w_row_end = ((r_v_cnt & V_MASK) == V_MASK);
  assign w_col     = ADDR_WIDTH'(w_h_img);
  assign w_nib     = pixel_data_i[DATA_WIDTH-1 -: 4];
  assign w_unused_pix = ^pixel_data_i;

  // Stage-0 flags decoded straight from the counters.
  always_comb begin
    w_flags        = FLAGS_RST;
    w_flags.hs     = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
    w_flags.vs     = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));
    w_flags.active = w_active;
    w_flags.in_img = w_in_img;
    w_flags.first  = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  // Horizontal and vertical raster counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + V_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + H_W'(1);
    end
  end

  // Running row base address (image row * IMG_W) kept by addition; a frame
  // wrap takes priority over the per-row increment.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_line_base <= '0;
    end else if (w_h_wrap) begin
      if (w_v_wrap) begin
        r_line_base <= '0;
      end else if (w_row_end && (32'(w_v_img) < IMG_H - 1)) begin
        r_line_base <= r_line_base + ADDR_WIDTH'(IMG_W);
      end
    end
  end

  // Registered VRAM read address; holds outside the image so no stray reads.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_addr <= '0;
    end else if (w_in_img) begin
      r_addr <= r_line_base + w_col;
    end
  end

  // Delay line matching the flags to the returning VRAM data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i <= READ_LATENCY; i++) begin
        r_pipe[i] <= FLAGS_RST;
      end
    end else begin
      r_pipe[0] <= w_flags;
      for (int unsigned i = 1; i <= READ_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Output register: gray replicated to RGB inside the image, black elsewhere.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_en    <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= r_pipe[READ_LATENCY].hs;
      r_vsync       <= r_pipe[READ_LATENCY].vs;
      r_video_en    <= r_pipe[READ_LATENCY].active;
      r_rgb         <= r_pipe[READ_LATENCY].in_img ? {3{w_nib}} : '0;
      r_frame_start <= r_pipe[READ_LATENCY].first;
    end
  end

  assign pixel_read_address_o = r_addr;
  assign hsync_o              = r_hsync;
  assign vsync_o              = r_vsync;
  assign video_en_o           = r_video_en;
  assign rgb_o                = r_rgb;
  assign frame_start_o        = r_frame_start;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: a default-timing instance, a cropped
// image instance (160x120) and a miniature-timing instance that makes full
// frame checks short. Each has a 1-clock VRAM stub returning addr[7:0].
module tb_vga_frame_reader;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc_a, cyc_b;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  logic [16:0] a_addr, c_addr, s_addr;
  logic [7:0]  a_data, c_data, s_data;
  logic        a_hs, a_vs, a_en, a_fs;
  logic        c_hs, c_vs, c_en, c_fs;
  logic        s_hs, s_vs, s_en, s_fs;
  logic [11:0] a_rgb, c_rgb, s_rgb;

  vga_frame_reader u_dut (
    .clk_i(clk), .reset_i(rst_a), .pixel_data_i(a_data),
    .pixel_read_address_o(a_addr), .hsync_o(a_hs), .vsync_o(a_vs),
    .video_en_o(a_en), .rgb_o(a_rgb), .frame_start_o(a_fs)
  );

  vga_frame_reader #(.IMG_W(160), .IMG_H(120)) u_crop (
    .clk_i(clk), .reset_i(rst_a), .pixel_data_i(c_data),
    .pixel_read_address_o(c_addr), .hsync_o(c_hs), .vsync_o(c_vs),
    .video_en_o(c_en), .rgb_o(c_rgb), .frame_start_o(c_fs)
  );

  vga_frame_reader #(
    .IMG_W(8), .IMG_H(4),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk_i(clk), .reset_i(rst_b), .pixel_data_i(s_data),
    .pixel_read_address_o(s_addr), .hsync_o(s_hs), .vsync_o(s_vs),
    .video_en_o(s_en), .rgb_o(s_rgb), .frame_start_o(s_fs)
  );

  // VRAM stubs: one clock of read latency, data = low address byte.
  always @(posedge clk) begin
    a_data <= a_addr[7:0];
    c_data <= c_addr[7:0];
    s_data <= s_addr[7:0];
  end

  // Cycle index since reset release equals the DUT raster position.
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) cyc_a <= 0;
    else       cyc_a <= cyc_a + 1;
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) cyc_b <= 0;
    else       cyc_b <= cyc_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_a(input int n);
    while (cyc_a < n) @(negedge clk);
  endtask

  task automatic wait_b(input int n);
    while (cyc_b < n) @(negedge clk);
  endtask

  int   hs_low, vs_low, en_hi, fs_n, nhf, nvf, steps;
  int   hs_fall [2];
  int   vs_fall [2];
  int   fs_at   [2];
  logic prev_hs, prev_vs;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hs",   32'(a_hs),   1);
    check("rst_vs",   32'(a_vs),   1);
    check("rst_en",   32'(a_en),   0);
    check("rst_rgb",  32'(a_rgb),  0);
    check("rst_fs",   32'(a_fs),   0);
    check("rst_addr", 32'(a_addr), 0);
    check("rst_s_hs", 32'(s_hs),   1);
    check("rst_s_vs", 32'(s_vs),   1);

    // ---------------- miniature timing: two full frames ----------------
    rst_b = 1'b0;
    hs_low = 0; vs_low = 0; en_hi = 0; fs_n = 0; nhf = 0; nvf = 0;
    hs_fall = '{-1, -1}; vs_fall = '{-1, -1}; fs_at = '{-1, -1};
    wait_b(2);
    check("s_en_pre", 32'(s_en), 0);
    prev_hs = s_hs;
    prev_vs = s_vs;
    for (int n = 3; n < 579; n++) begin
      wait_b(n);
      if (!s_hs) hs_low++;
      if (!s_vs) vs_low++;
      if (s_en)  en_hi++;
      if (s_fs) begin
        if (fs_n < 2) fs_at[fs_n] = n;
        fs_n++;
      end
      if (prev_hs && !s_hs && nhf < 2) begin hs_fall[nhf] = n; nhf++; end
      if (prev_vs && !s_vs && nvf < 2) begin vs_fall[nvf] = n; nvf++; end
      prev_hs = s_hs;
      prev_vs = s_vs;
      if (n == 103) check("s_rgb_4_4",    32'(s_rgb),  32'h111);
      if (n == 184) check("s_last_addr",  32'(s_addr), 31);
      if (n == 186) check("s_last_rgb",   32'(s_rgb),  32'h111);
      if (n == 287) check("s_addr_hold",  32'(s_addr), 31);
      if (n == 289) check("s_addr_frm2",  32'(s_addr), 0);
      if (n == 291) check("s_en_at_fs",   32'(s_en),   1);
    end
    check("s_hs_low_cnt", 32'(hs_low), 96);
    check("s_vs_low_cnt", 32'(vs_low), 96);
    check("s_en_cnt",     32'(en_hi),  256);
    check("s_fs_cnt",     32'(fs_n),   2);
    check("s_fs0_at",     32'(fs_at[0]), 3);
    check("s_fs1_at",     32'(fs_at[1]), 291);
    check("s_hs_fall0",   32'(hs_fall[0]), 21);
    check("s_hs_fall1",   32'(hs_fall[1]), 45);
    check("s_vs_fall0",   32'(vs_fall[0]), 219);
    check("s_vs_fall1",   32'(vs_fall[1]), 507);

    // mid-frame asynchronous reset at raster (10,5) of the third frame
    wait_b(706);
    check("s_pre_rst_rgb", 32'(s_rgb), 32'h111);
    check("s_pre_rst_en",  32'(s_en),  1);
    #2 rst_b = 1'b1;
    #1;
    check("s_mid_rst_en",   32'(s_en),   0);
    check("s_mid_rst_rgb",  32'(s_rgb),  0);
    check("s_mid_rst_addr", 32'(s_addr), 0);
    check("s_mid_rst_hs",   32'(s_hs),   1);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    steps = 0;
    while (s_hs && steps < 200) begin
      @(posedge clk);
      #1;
      steps++;
    end
    check("s_hs_after_rst", 32'(steps), 21);

    // ---------------- default timing ----------------
    @(negedge clk);
    rst_a = 1'b0;
    wait_a(1);
    check("addr_col0",    32'(a_addr), 0);
    wait_a(2);
    check("addr_col1",    32'(a_addr), 0);
    check("en_pre",       32'(a_en),   0);
    check("fs_pre",       32'(a_fs),   0);
    wait_a(3);
    check("addr_col2",    32'(a_addr), 1);
    check("fs_00",        32'(a_fs),   1);
    check("en_00",        32'(a_en),   1);
    check("rgb_00",       32'(a_rgb),  0);
    check("crop_fs_00",   32'(c_fs),   1);
    wait_a(4);
    check("fs_post",      32'(a_fs),   0);
    wait_a(658);
    check("hs_before",    32'(a_hs),   1);
    wait_a(659);
    check("hs_fall",      32'(a_hs),   0);
    check("vs_line0",     32'(a_vs),   1);
    wait_a(754);
    check("hs_last_low",  32'(a_hs),   0);
    wait_a(755);
    check("hs_rise",      32'(a_hs),   1);
    wait_a(801);
    check("addr_line1",   32'(a_addr), 0);
    hs_low = 0; nhf = 0; hs_fall[0] = -1;
    prev_hs = a_hs;
    for (int n = 803; n < 1603; n++) begin
      wait_a(n);
      if (!a_hs) hs_low++;
      if (prev_hs && !a_hs && nhf < 1) begin hs_fall[0] = n; nhf++; end
      prev_hs = a_hs;
      if (n == 1601) check("addr_line2", 32'(a_addr), 320);
    end
    check("hs_low_line1", 32'(hs_low),     96);
    check("hs_fall_l1",   32'(hs_fall[0]), 1459);
    wait_a(1603);
    check("addr_line2_c1", 32'(a_addr), 321);
    wait_a(2406);
    check("addr_5_3",     32'(a_addr), 322);
    wait_a(2408);
    check("rgb_5_3",      32'(a_rgb),  32'h444);
    check("en_5_3",       32'(a_en),   1);

    // cropped image: columns >= 320 of the active area are black
    wait_a(8319);
    check("crop_addr_edge", 32'(c_addr), 959);
    wait_a(8321);
    check("crop_rgb_edge",  32'(c_rgb),  32'hBBB);
    wait_a(8400);
    check("crop_addr_hold", 32'(c_addr), 959);
    wait_a(8401);
    check("crop_addr_hold2", 32'(c_addr), 959);
    check("addr_400_10",    32'(a_addr), 1800);
    wait_a(8403);
    check("crop_rgb_black", 32'(c_rgb), 0);
    check("crop_en",        32'(c_en),  1);

    // mid-line asynchronous reset at raster (300,12)
    wait_a(9900);
    check("pre_rst_rgb", 32'(a_rgb), 32'h111);
    check("pre_rst_en",  32'(a_en),  1);
    #2 rst_a = 1'b1;
    #1;
    check("mid_rst_en",   32'(a_en),   0);
    check("mid_rst_rgb",  32'(a_rgb),  0);
    check("mid_rst_addr", 32'(a_addr), 0);
    check("mid_rst_vs",   32'(a_vs),   1);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    steps = 0;
    while (a_hs && steps < 2000) begin
      @(posedge clk);
      #1;
      steps++;
    end
    check("hs_after_rst", 32'(steps), 659);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
